switch_debounce_select: RTL and testbench

- Conditions a raw, bouncing slide-switch or push-button input into a clean, glitch-free select level.
- Drives the select input of the 1-bit 2:1 mux stage directly; that mux's output goes to the board LED.
- Consists of a two-flop synchronizer, a stability counter and an optional toggle register.
- Also emits one-cycle edge pulses for other consumers, e.g. counters and LED blinkers.

---
 rtl/debounce_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/switch_debounce_select.sv | 70 +++++++
 tb/tb_switch_debounce_select.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared constants and state type for the switch debounce logic.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package debounce_pkg;

    // 10 ms at 50 MHz for real boards; a short filter keeps simulation fast
    localparam int DEFAULT_STABLE_CYCLES = 500000;
    localparam int SIM_STABLE_CYCLES     = 4;

    // Values for the TOGGLE_MODE parameter
    localparam int MODE_LEVEL  = 0;
    localparam int MODE_TOGGLE = 1;

    // Accepted (debounced) level of the switch
    typedef enum logic {
        STABLE_LO = 1'b0,
        STABLE_HI = 1'b1
    } db_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing one asynchronous level into the CLK domain.
// Latency: 2 clock edges from input sample to synced output.
// Backpressure: none; free-running level path.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic synced
);

    logic sync1;

    // First stage may go metastable; only the second stage is used downstream
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= 1'b0;
            synced <= 1'b0;
        end else begin
            sync1  <= level;
            synced <= sync1;
        end
    end

endmodule

// File: rtl/switch_debounce_select.sv
// Debounces a raw switch into a clean mux select plus one-cycle edge pulses.
// Latency: STABLE_CYCLES+1 edges after the input is first sampled.
// Backpressure: none; level output and single-cycle pulses, no handshake.
module switch_debounce_select
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int TOGGLE_MODE   = MODE_LEVEL
) (
    input  logic CLK,
    input  logic RST,
    input  logic SW_IN,
    output logic S,
    output logic RISE,
    output logic FALL
);

    localparam int               CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             sync2;
    db_state_t        db_state;
    logic [CNT_W-1:0] cnt;
    logic             differs;
    logic             accept;

    sync_2ff u_sync (
        .clk    (CLK),
        .rst    (RST),
        .level  (SW_IN),
        .synced (sync2)
    );

    // Accept once the synced input has disagreed for STABLE_CYCLES edges in a row
    assign differs = (db_state_t'(sync2) != db_state);
    assign accept  = differs && (cnt == CNT_LAST);

    // Stability counter, accepted level, edge pulses and select output
    always_ff @(posedge CLK) begin
        if (RST) begin
            db_state <= STABLE_LO;
            cnt      <= '0;
            S        <= 1'b0;
            RISE     <= 1'b0;
            FALL     <= 1'b0;
        end else begin
            RISE <= accept && sync2;
            FALL <= accept && !sync2;

            if (!differs) begin
                // Bounce back to the accepted level throws away progress
                cnt <= '0;
            end else if (accept) begin
                db_state <= db_state_t'(sync2);
                cnt      <= '0;
                if (TOGGLE_MODE == MODE_TOGGLE) begin
                    // Press-to-toggle: only accepted presses flip the select
                    if (sync2) begin
                        S <= ~S;
                    end
                end else begin
                    S <= sync2;
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_switch_debounce_select.sv
// Self-checking bench for switch_debounce_select using an event scoreboard.
// Expected pulse edges come from the documented latency, not from the DUT.
// Three instances: level mode, toggle mode, and the one-cycle filter.
module tb_switch_debounce_select;
    import debounce_pkg::*;

    localparam int N = SIM_STABLE_CYCLES;

    typedef struct {
        int edge_n;
        bit rise;
        bit s;
    } evt_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic sw_lvl = 1'b0, sw_tog = 1'b0, sw_min = 1'b0;
    logic s_lvl, rise_lvl, fall_lvl;
    logic s_tog, rise_tog, fall_tog;
    logic s_min, rise_min, fall_min;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   tog_model = 1'b0;
    logic rst_seen = 1'b0;
    logic s_exp [3];
    evt_t q [3][$];

    switch_debounce_select #(.STABLE_CYCLES(N), .TOGGLE_MODE(MODE_LEVEL)) u_lvl (
        .CLK(CLK), .RST(RST), .SW_IN(sw_lvl), .S(s_lvl), .RISE(rise_lvl), .FALL(fall_lvl)
    );

    switch_debounce_select #(.STABLE_CYCLES(N), .TOGGLE_MODE(MODE_TOGGLE)) u_tog (
        .CLK(CLK), .RST(RST), .SW_IN(sw_tog), .S(s_tog), .RISE(rise_tog), .FALL(fall_tog)
    );

    switch_debounce_select #(.STABLE_CYCLES(1), .TOGGLE_MODE(MODE_LEVEL)) u_min (
        .CLK(CLK), .RST(RST), .SW_IN(sw_min), .S(s_min), .RISE(rise_min), .FALL(fall_min)
    );

    always #5 CLK = ~CLK;

    // Edge index and whether that edge was a reset edge
    always @(posedge CLK) begin
        cyc      <= cyc + 1;
        rst_seen <= RST;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at edge %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Queue the pulse expected from an input change driven just after the current edge
    task automatic expect_at(input int id, input bit rise);
        evt_t e;
        int   lat;
        lat      = (id == 2) ? 1 : N;
        e.edge_n = cyc + 2 + lat;
        e.rise   = rise;
        if (id == 1) begin
            if (rise) tog_model = ~tog_model;
            e.s = tog_model;
        end else begin
            e.s = rise;
        end
        q[id].push_back(e);
    endtask

    task automatic mon(input int id, input logic r, input logic f, input logic s);
        evt_t  e;
        string p;
        p = (id == 0) ? "lvl" : (id == 1) ? "tog" : "min";
        if (rst_seen) begin
            chk({p, "_reset_S"}, s, 0);
            chk({p, "_reset_RISE"}, r, 0);
            chk({p, "_reset_FALL"}, f, 0);
            s_exp[id] = 1'b0;
        end else if (r === 1'b1 || f === 1'b1) begin
            chk({p, "_rise_fall_exclusive"}, r && f, 0);
            if (q[id].size() == 0) begin
                chk({p, "_unexpected_pulse"}, 1, 0);
            end else begin
                e = q[id].pop_front();
                chk({p, "_event_edge"}, cyc, e.edge_n);
                chk({p, "_event_is_rise"}, r, e.rise);
                chk({p, "_event_S"}, s, e.s);
                s_exp[id] = e.s;
            end
        end else begin
            chk({p, "_S_steady"}, s, s_exp[id]);
        end
    endtask

    always @(negedge CLK) begin
        mon(0, rise_lvl, fall_lvl, s_lvl);
        mon(1, rise_tog, fall_tog, s_tog);
        mon(2, rise_min, fall_min, s_min);
    end

    task automatic drain();
        int i = 0;
        while (i < 60 && (q[0].size() + q[1].size() + q[2].size()) != 0) begin
            step();
            i++;
        end
        chk("drain_pending", q[0].size() + q[1].size() + q[2].size(), 0);
        repeat (3) step();
    endtask

    initial begin
        repeat (3) step();
        RST = 1'b0;
        repeat (5) step();

        // Switch held high through reset: accepted after release
        RST = 1'b1;
        sw_lvl = 1'b1;
        tog_model = 1'b0;
        repeat (3) step();
        RST = 1'b0;
        expect_at(0, 1'b1);
        repeat (12) step();
        sw_lvl = 1'b0;
        expect_at(0, 1'b0);
        drain();

        // Clean press and release, level mode
        sw_lvl = 1'b1;
        expect_at(0, 1'b1);
        repeat (20) step();
        sw_lvl = 1'b0;
        expect_at(0, 1'b0);
        drain();

        // Bounce 1,0,1,0 in 2-cycle runs, then a stable 1
        for (int i = 0; i < 5; i++) begin
            sw_lvl = (i % 2 == 0);
            if (i == 4) expect_at(0, 1'b1);
            repeat (2) step();
        end
        repeat (10) step();
        sw_lvl = 1'b0;
        expect_at(0, 1'b0);
        drain();

        // Three presses in toggle mode
        for (int p = 0; p < 3; p++) begin
            sw_tog = 1'b1;
            expect_at(1, 1'b1);
            repeat (10) step();
            sw_tog = 1'b0;
            expect_at(1, 1'b0);
            repeat (10) step();
        end
        drain();

        // Reset while the counter sits at 2
        sw_lvl = 1'b1;
        repeat (4) step();
        RST = 1'b1;
        tog_model = 1'b0;
        step();
        RST = 1'b0;
        expect_at(0, 1'b1);
        repeat (10) step();
        sw_lvl = 1'b0;
        expect_at(0, 1'b0);
        drain();

        // One-cycle pulse through the minimum filter
        sw_min = 1'b1;
        expect_at(2, 1'b1);
        step();
        sw_min = 1'b0;
        expect_at(2, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
